moving_average_sequencer: RTL and testbench

MOVING_AVERAGE_SEQUENCER -- requirements
Module: moving_average_sequencer

---
 rtl/interfaces_pkg.sv | 17 +
 rtl/settings_pkg.sv | 19 +
 rtl/moving_average_sequencer.sv | 159 +++++++++++++++
 tb/tb_moving_average_sequencer.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/interfaces_pkg.sv
// Handshake bundles between the sequencer, its sample source and the
// moving-average datapath result stream.
package interfaces_pkg;

  // Source-to-datapath feed: ready toward the source, enable toward the datapath.
  typedef struct packed {
    logic ready;
    logic enable;
  } feed_t;

  // Datapath result acceptance: valid result counted this cycle, last result of the job.
  typedef struct packed {
    logic valid;
    logic last;
  } result_t;

endpackage

// File: rtl/settings_pkg.sv
// Shared settings for the moving-average sequencer: parameter defaults and
// the job-level state encoding.
package settings_pkg;

  localparam int unsigned DEF_DATA_WIDTH    = 16;
  localparam int unsigned DEF_WINDOW_WIDTH  = 4;
  localparam int unsigned DEF_COUNT_WIDTH   = 16;
  localparam int unsigned DEF_CONFIG_CYCLES = 2;
  localparam int unsigned DEF_DRAIN_TIMEOUT = 64;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CONFIG = 3'd1,
    ST_RUN    = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

endpackage

// File: rtl/moving_average_sequencer.sv
// Job sequencer for a moving-average datapath: configures the window, feeds a
// fixed number of samples, collects results and drains with a bounded timer.
module moving_average_sequencer
  import settings_pkg::*;
  import interfaces_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int unsigned WINDOW_WIDTH  = DEF_WINDOW_WIDTH,
  parameter int unsigned COUNT_WIDTH   = DEF_COUNT_WIDTH,
  parameter int unsigned CONFIG_CYCLES = DEF_CONFIG_CYCLES,
  parameter int unsigned DRAIN_TIMEOUT = DEF_DRAIN_TIMEOUT
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [WINDOW_WIDTH-1:0] cfg_window,
  input  logic [COUNT_WIDTH-1:0]  cfg_count,
  input  logic                    abort,
  output logic                    busy,
  output logic                    done,
  output logic                    aborted,
  output logic                    timeout,
  input  logic [DATA_WIDTH-1:0]   s_data,
  input  logic                    s_valid,
  output logic                    s_ready,
  output logic [DATA_WIDTH-1:0]   ma_input_data,
  output logic                    ma_enable,
  output logic [WINDOW_WIDTH-1:0] ma_window,
  input  logic [DATA_WIDTH-1:0]   ma_output_data,
  input  logic                    ma_output_data_valid,
  output logic [DATA_WIDTH-1:0]   m_data,
  output logic                    m_valid
);

  localparam int unsigned TIMER_W = $clog2(DRAIN_TIMEOUT + 1);
  localparam int unsigned CFG_W   = (CONFIG_CYCLES > 1) ? $clog2(CONFIG_CYCLES) : 1;

  state_t                  state, state_next;
  logic [COUNT_WIDTH-1:0]  count, sent, rcvd, sent_inc, rcvd_inc;
  logic [TIMER_W-1:0]      timer, timer_inc;
  logic [CFG_W-1:0]        cfg_cnt;
  feed_t                   feed;
  result_t                 res;
  logic                    job_start, abort_take, timeout_set;

  // Next-state and handshake decode; abort overrides every transition.
  always_comb begin
    state_next  = state;
    feed        = '0;
    res         = '0;
    job_start   = 1'b0;
    timeout_set = 1'b0;
    sent_inc    = sent + COUNT_WIDTH'(1);
    rcvd_inc    = rcvd + COUNT_WIDTH'(1);
    timer_inc   = timer + TIMER_W'(1);
    abort_take  = abort && (state != ST_IDLE);

    if (state == ST_RUN) begin
      feed.ready = (sent != count) && !abort;
    end
    feed.enable = feed.ready && s_valid;

    if (((state == ST_RUN) || (state == ST_DRAIN)) && (rcvd != count)) begin
      res.valid = ma_output_data_valid;
    end
    res.last = (rcvd == count) || (res.valid && (rcvd_inc == count));

    case (state)
      ST_IDLE: begin
        if (start) begin
          job_start  = 1'b1;
          state_next = ST_CONFIG;
        end
      end
      ST_CONFIG: begin
        if (cfg_cnt == CFG_W'(CONFIG_CYCLES - 1)) begin
          state_next = (count == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        if (feed.enable && (sent_inc == count)) begin
          state_next = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // A result landing on the timeout cycle still completes the job cleanly.
        if (res.last) begin
          state_next = ST_DONE;
        end else if (timer_inc == TIMER_W'(DRAIN_TIMEOUT)) begin
          state_next  = ST_DONE;
          timeout_set = 1'b1;
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase

    if (abort_take) begin
      state_next  = ST_IDLE;
      timeout_set = 1'b0;
    end
  end

  // State, job configuration, counters and sticky/pulse flags.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= ST_IDLE;
      ma_window <= '0;
      count     <= '0;
      sent      <= '0;
      rcvd      <= '0;
      timer     <= '0;
      cfg_cnt   <= '0;
      timeout   <= 1'b0;
      aborted   <= 1'b0;
    end else begin
      state   <= state_next;
      aborted <= abort_take;
      if (job_start) begin
        ma_window <= cfg_window;
        count     <= cfg_count;
        sent      <= '0;
        rcvd      <= '0;
        timer     <= '0;
        cfg_cnt   <= '0;
        timeout   <= 1'b0;
      end else begin
        if (state == ST_CONFIG) begin
          cfg_cnt <= cfg_cnt + CFG_W'(1);
        end
        if (feed.enable) begin
          sent <= sent_inc;
        end
        if (res.valid && !abort_take) begin
          rcvd <= rcvd_inc;
        end
        if (state == ST_DRAIN) begin
          timer <= timer_inc;
        end
        if (timeout_set) begin
          timeout <= 1'b1;
        end
      end
    end
  end

  assign s_ready       = feed.ready;
  assign ma_enable     = feed.enable;
  assign ma_input_data = s_data;
  assign m_data        = ma_output_data;
  assign m_valid       = res.valid;
  assign busy          = (state != ST_IDLE);
  assign done          = (state == ST_DONE) && !abort;

endmodule

// File: tb/tb_moving_average_sequencer.sv
// Bench for moving_average_sequencer: job table plus abort and reset sequences,
// with a two-cycle echo datapath model and a result scoreboard.
module tb_moving_average_sequencer;

  localparam int unsigned DW = 16;
  localparam int unsigned WW = 4;
  localparam int unsigned CW = 16;
  localparam logic [DW-1:0] KEY = 16'hA5C3;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [WW-1:0] cfg_window;
  logic [CW-1:0] cfg_count;
  logic          abort;
  logic          busy, done, aborted, timeout;
  logic [DW-1:0] s_data;
  logic          s_valid, s_ready;
  logic [DW-1:0] ma_input_data;
  logic          ma_enable;
  logic [WW-1:0] ma_window;
  logic [DW-1:0] ma_output_data;
  logic          ma_output_data_valid;
  logic [DW-1:0] m_data;
  logic          m_valid;

  always #5 clk = ~clk;

  moving_average_sequencer dut (
    .clk                  (clk),
    .reset                (reset),
    .start                (start),
    .cfg_window           (cfg_window),
    .cfg_count            (cfg_count),
    .abort                (abort),
    .busy                 (busy),
    .done                 (done),
    .aborted              (aborted),
    .timeout              (timeout),
    .s_data               (s_data),
    .s_valid              (s_valid),
    .s_ready              (s_ready),
    .ma_input_data        (ma_input_data),
    .ma_enable            (ma_enable),
    .ma_window            (ma_window),
    .ma_output_data       (ma_output_data),
    .ma_output_data_valid (ma_output_data_valid),
    .m_data               (m_data),
    .m_valid              (m_valid)
  );

  // Datapath stand-in: scrambles each input and returns it two cycles later,
  // emitting at most dp_limit results per job.
  logic          p1_v = 1'b0, p2_v = 1'b0;
  logic [DW-1:0] p1_d = '0, p2_d = '0;
  int            dp_limit = 0;
  int            dp_cnt = 0;

  always @(posedge clk) begin
    if (start && !busy) dp_cnt <= 0;
    else if (ma_enable) dp_cnt <= dp_cnt + 1;
    p1_v <= ma_enable && (dp_cnt < dp_limit);
    p1_d <= ma_input_data ^ KEY;
    p2_v <= p1_v;
    p2_d <= p1_d;
  end

  assign ma_output_data_valid = p2_v;
  assign ma_output_data       = p2_d;

  typedef struct {
    int win;
    int cnt;
    bit toggle;
    int limit;
    int restart_k;
    int exp_en;
    int exp_mv;
    int exp_done_k;
    bit exp_to;
  } job_t;

  job_t          jobs[6];
  logic [DW-1:0] sb_q[$];
  int            n_checks = 0;
  int            n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Called at the negedge: queue each accepted sample, compare each result.
  task automatic sb_sample();
    if (ma_enable) sb_q.push_back(s_data ^ KEY);
    if (m_valid) begin
      if (sb_q.size() == 0) check("sb_underflow", 32'd1, 32'd0);
      else check("m_data", m_data, sb_q.pop_front());
    end
  endtask

  task automatic run_job(input job_t j, output int en, output int mv, output int done_k,
                         output int dones, output int to_at_done, output int to_after,
                         output int win_err, output int ready_after, output int en_wo_valid);
    en = 0; mv = 0; done_k = -1; dones = 0; to_at_done = -1; to_after = -1;
    win_err = 0; ready_after = 0; en_wo_valid = 0;
    sb_q.delete();
    dp_limit = j.limit;
    @(posedge clk); #1;
    start = 1'b1; cfg_window = WW'(j.win); cfg_count = CW'(j.cnt);
    s_valid = 1'b0; abort = 1'b0;
    @(negedge clk);
    for (int k = 1; k <= 200; k++) begin
      @(posedge clk); #1;
      start      = (k == j.restart_k);
      cfg_window = ~WW'(j.win);
      cfg_count  = '1;
      s_valid    = j.toggle ? ((k % 2) == 1) : 1'b1;
      s_data     = DW'($urandom);
      @(negedge clk);
      if ((en >= j.cnt) && s_ready) ready_after++;
      if (ma_enable) en++;
      if (ma_enable && !s_valid) en_wo_valid++;
      if (m_valid) mv++;
      if (busy && (ma_window != WW'(j.win))) win_err++;
      if (done) begin
        dones++;
        if (done_k < 0) begin
          done_k     = k;
          to_at_done = int'(timeout);
        end
      end
      sb_sample();
      if ((done_k >= 0) && (k == done_k + 2)) begin
        to_after = int'(timeout);
        break;
      end
    end
    @(posedge clk); #1;
    start = 1'b0; s_valid = 1'b0;
  endtask

  initial begin
    int en, mv, done_k, dones, to_d, to_a, win_err, rdy_after, en_nv, dcount;
    job_t j;

    //          win cnt tog lim rst en mv done to
    jobs[0] = '{3,  8,  0,  8,  0,  8, 8, 13,  0};
    jobs[1] = '{1,  0,  0,  0,  0,  0, 0, 3,   0};
    jobs[2] = '{5,  4,  1,  4,  0,  4, 4, 12,  0};
    jobs[3] = '{2,  5,  0,  3,  0,  5, 3, 72,  1};
    jobs[4] = '{9,  1,  0,  1,  0,  1, 1, 6,   0};
    jobs[5] = '{6,  3,  0,  3,  4,  3, 3, 8,   0};

    reset = 1'b0; start = 1'b0; abort = 1'b0; cfg_window = '0; cfg_count = '0;
    s_data = '0; s_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_aborted", aborted, 0);
    check("rst_timeout", timeout, 0);
    check("rst_s_ready", s_ready, 0);
    check("rst_ma_enable", ma_enable, 0);
    check("rst_m_valid", m_valid, 0);
    check("rst_ma_window", ma_window, 0);
    @(posedge clk); #1; reset = 1'b1;
    @(negedge clk);

    for (int r = 0; r < 6; r++) begin
      run_job(jobs[r], en, mv, done_k, dones, to_d, to_a, win_err, rdy_after, en_nv);
      check($sformatf("job%0d_enables", r), en, jobs[r].exp_en);
      check($sformatf("job%0d_m_valids", r), mv, jobs[r].exp_mv);
      check($sformatf("job%0d_done_cycle", r), done_k, jobs[r].exp_done_k);
      check($sformatf("job%0d_done_pulses", r), dones, 1);
      check($sformatf("job%0d_timeout_at_done", r), to_d, jobs[r].exp_to);
      check($sformatf("job%0d_timeout_held", r), to_a, jobs[r].exp_to);
      check($sformatf("job%0d_window", r), win_err, 0);
      check($sformatf("job%0d_ready_after_last", r), rdy_after, 0);
      check($sformatf("job%0d_enable_without_valid", r), en_nv, 0);
    end

    // Abort in RUN after two samples, then a fresh job with window 7.
    sb_q.delete(); dp_limit = 8; en = 0; dcount = 0;
    @(posedge clk); #1;
    start = 1'b1; cfg_window = 4'd4; cfg_count = 16'd8;
    @(negedge clk);
    for (int k = 1; k <= 7; k++) begin
      @(posedge clk); #1;
      start = 1'b0; s_valid = 1'b1; s_data = DW'($urandom);
      abort = (k == 5);
      @(negedge clk);
      if (done) dcount++;
      if (k == 5) begin
        check("abort_samples_before", en, 2);
        check("abort_s_ready", s_ready, 0);
        check("abort_ma_enable", ma_enable, 0);
      end
      if (k == 6) begin
        check("abort_pulse", aborted, 1);
        check("abort_busy", busy, 0);
      end
      if (k == 7) check("abort_pulse_width", aborted, 0);
      if (ma_enable) en++;
      sb_sample();
    end
    check("abort_no_done", dcount, 0);
    @(posedge clk); #1; abort = 1'b0; s_valid = 1'b0;
    j = '{7, 0, 0, 0, 0, 0, 0, 3, 0};
    run_job(j, en, mv, done_k, dones, to_d, to_a, win_err, rdy_after, en_nv);
    check("restart_window7", win_err, 0);
    check("restart_done_cycle", done_k, 3);
    check("restart_window_value", ma_window, 7);

    // Reset while in DRAIN discards the job silently.
    sb_q.delete(); dp_limit = 0; dcount = 0;
    @(posedge clk); #1;
    start = 1'b1; cfg_window = 4'd2; cfg_count = 16'd5;
    @(negedge clk);
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      start = 1'b0; s_valid = 1'b1; s_data = DW'($urandom);
      reset = (k != 10);
      @(negedge clk);
      if (done) dcount++;
    end
    @(posedge clk); #1;
    @(negedge clk);
    check("drain_rst_busy", busy, 0);
    check("drain_rst_done", done, 0);
    check("drain_rst_aborted", aborted, 0);
    check("drain_rst_timeout", timeout, 0);
    check("drain_rst_s_ready", s_ready, 0);
    check("drain_rst_ma_enable", ma_enable, 0);
    check("drain_rst_m_valid", m_valid, 0);
    check("drain_rst_ma_window", ma_window, 0);
    @(posedge clk); #1; reset = 1'b1;
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      if (done || aborted) dcount++;
    end
    check("drain_rst_no_pulses", dcount, 0);
    check("drain_rst_idle", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
